// File: rtl/wb_bus_pkg.sv
// Shared types and constants for the Wishbone single-master shared-bus interconnect.
package wb_bus_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DECODE_ERR,
        TO_ERR
    } bus_state_e;

    typedef enum logic [1:0] {
        RESP_NONE,
        RESP_ACK,
        RESP_ERR,
        RESP_RTY
    } resp_e;

    // A slave raising several terminations at once is resolved err > rty > ack.
    function automatic resp_e resolve_resp(input logic ack, input logic err, input logic rty);
        if (err) begin
            return RESP_ERR;
        end
        if (rty) begin
            return RESP_RTY;
        end
        if (ack) begin
            return RESP_ACK;
        end
        return RESP_NONE;
    endfunction

endpackage

// File: rtl/wb_addr_decoder.sv
// Combinational base/mask address decoder; overlapping windows resolve to the lowest slave index.
module wb_addr_decoder
    import wb_bus_pkg::*;
#(
    parameter int                            N_SLAVES   = 4,
    parameter int                            IDX_W      = 2,
    parameter logic [N_SLAVES*WB_ADR_W-1:0]  SLAVE_BASE = {N_SLAVES{32'h0}},
    parameter logic [N_SLAVES*WB_ADR_W-1:0]  SLAVE_MASK = {N_SLAVES{32'hF000_0000}}
) (
    input  logic [WB_ADR_W-1:0] adr_i,
    output logic                hit_o,
    output logic [IDX_W-1:0]    sel_idx_o
);

    // NOTE: combinational blocks use blocking '=' with every output defaulted first,
    // so the loop reads its own running result and no latch is inferred.
    always_comb begin
        hit_o     = 1'b0;
        sel_idx_o = '0;
        // Scanning downwards lets the lowest hitting index overwrite the others.
        for (int k = N_SLAVES - 1; k >= 0; k--) begin
            if ((adr_i & SLAVE_MASK[k*WB_ADR_W +: WB_ADR_W]) ==
                (SLAVE_BASE[k*WB_ADR_W +: WB_ADR_W] & SLAVE_MASK[k*WB_ADR_W +: WB_ADR_W])) begin
                hit_o     = 1'b1;
                sel_idx_o = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/wb_shared_bus.sv
// Wishbone classic single-master, N-slave interconnect with decode/watchdog bus errors
// and a latched fault address.
module wb_shared_bus
    import wb_bus_pkg::*;
#(
    parameter int                            N_SLAVES       = 4,
    parameter logic [N_SLAVES*WB_ADR_W-1:0]  SLAVE_BASE     = {N_SLAVES{32'h0}},
    parameter logic [N_SLAVES*WB_ADR_W-1:0]  SLAVE_MASK     = {N_SLAVES{32'hF000_0000}},
    parameter int                            TIMEOUT_CYCLES = 255
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         m_cyc_i,
    input  logic                         m_stb_i,
    input  logic                         m_we_i,
    input  logic [WB_ADR_W-1:0]          m_adr_i,
    input  logic [WB_SEL_W-1:0]          m_sel_i,
    input  logic [WB_DAT_W-1:0]          m_dat_i,
    output logic [WB_DAT_W-1:0]          m_dat_o,
    output logic                         m_ack_o,
    output logic                         m_err_o,
    output logic                         m_rty_o,
    output logic [N_SLAVES-1:0]          s_cyc_o,
    output logic [N_SLAVES-1:0]          s_stb_o,
    output logic                         s_we_o,
    output logic [WB_ADR_W-1:0]          s_adr_o,
    output logic [WB_SEL_W-1:0]          s_sel_o,
    output logic [WB_DAT_W-1:0]          s_dat_o,
    input  logic [N_SLAVES*WB_DAT_W-1:0] s_dat_i,
    input  logic [N_SLAVES-1:0]          s_ack_i,
    input  logic [N_SLAVES-1:0]          s_err_i,
    input  logic [N_SLAVES-1:0]          s_rty_i,
    output logic                         fault_o,
    output logic [WB_ADR_W-1:0]          fault_adr_o
);

    localparam int          IDX_W   = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam logic [15:0] TIMEOUT = 16'(TIMEOUT_CYCLES);

    bus_state_e            state_q, state_d;
    logic [IDX_W-1:0]      sel_idx_q, sel_idx_d;
    logic [15:0]           wdog_q, wdog_d;
    logic [WB_ADR_W-1:0]   fault_adr_q, fault_adr_d;

    logic                  dec_hit;
    logic [IDX_W-1:0]      dec_idx;
    logic [WB_DAT_W-1:0]   s_dat_arr [N_SLAVES];
    resp_e                 resp;
    logic                  timed_out;
    logic                  err_state;

    wb_addr_decoder #(
        .N_SLAVES   (N_SLAVES),
        .IDX_W      (IDX_W),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decoder (
        .adr_i     (m_adr_i),
        .hit_o     (dec_hit),
        .sel_idx_o (dec_idx)
    );

    assign s_we_o      = m_we_i;
    assign s_adr_o     = m_adr_i;
    assign s_sel_o     = m_sel_i;
    assign s_dat_o     = m_dat_i;
    assign fault_adr_o = fault_adr_q;

    always_comb begin
        for (int k = 0; k < N_SLAVES; k++) begin
            s_dat_arr[k] = s_dat_i[k*WB_DAT_W +: WB_DAT_W];
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_idx_d   = sel_idx_q;
        wdog_d      = wdog_q;
        fault_adr_d = fault_adr_q;
        s_cyc_o     = '0;
        s_stb_o     = '0;
        m_dat_o     = '0;
        resp        = RESP_NONE;
        err_state   = 1'b0;
        timed_out   = (wdog_q == TIMEOUT);

        case (state_q)
            IDLE: begin
                if (m_cyc_i && m_stb_i) begin
                    if (dec_hit) begin
                        state_d   = ACTIVE;
                        sel_idx_d = dec_idx;
                        wdog_d    = '0;
                    end else begin
                        state_d = DECODE_ERR;
                    end
                end
            end
            ACTIVE: begin
                m_dat_o = s_dat_arr[sel_idx_q];
                // In the timeout cycle the slave is already released, so its response is ignored.
                if (!timed_out) begin
                    s_cyc_o[sel_idx_q] = m_cyc_i;
                    s_stb_o[sel_idx_q] = m_cyc_i & m_stb_i;
                    if (m_cyc_i) begin
                        resp = resolve_resp(s_ack_i[sel_idx_q], s_err_i[sel_idx_q],
                                            s_rty_i[sel_idx_q]);
                    end
                end
                if (!m_cyc_i) begin
                    state_d = IDLE;
                end else if (timed_out) begin
                    state_d = TO_ERR;
                end else if (resp != RESP_NONE) begin
                    state_d = IDLE;
                end else begin
                    wdog_d = wdog_q + 16'd1;
                end
            end
            DECODE_ERR, TO_ERR: begin
                err_state   = 1'b1;
                fault_adr_d = m_adr_i;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset dominates: no termination reaches the master during a reset cycle.
        m_ack_o = !rst_i && (resp == RESP_ACK);
        m_rty_o = !rst_i && (resp == RESP_RTY);
        m_err_o = !rst_i && ((resp == RESP_ERR) || err_state);
        fault_o = !rst_i && err_state;
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples the
    // pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            sel_idx_q   <= '0;
            wdog_q      <= '0;
            fault_adr_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_idx_q   <= sel_idx_d;
            wdog_q      <= wdog_d;
            fault_adr_q <= fault_adr_d;
        end
    end

endmodule

// File: tb/tb_wb_shared_bus.sv
// Self-checking bench: transfer-level reference model for a 4-slave bus plus directed
// scenarios, and a second instance with overlapping windows.
module tb_wb_shared_bus;

    localparam int N     = 4;
    localparam int T     = 8;
    localparam int NEVER = 1000;
    localparam logic [31:0] BASE_A [N] = '{32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 32'h4000_0000};
    localparam logic [31:0] MASK_A     = 32'hF000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          m_cyc = 1'b0, m_stb = 1'b0, m_we = 1'b0;
    logic [31:0]   m_adr = '0, m_dat_w = '0;
    logic [3:0]    m_sel = '0;
    logic [N*32-1:0] sa_dat = '0;
    logic [N-1:0]  sa_ack = '0, sa_err = '0, sa_rty = '0;

    logic [31:0]   a_m_dat, a_s_adr, a_s_dat, a_fault_adr;
    logic          a_m_ack, a_m_err, a_m_rty, a_s_we, a_fault;
    logic [N-1:0]  a_s_cyc, a_s_stb;
    logic [3:0]    a_s_sel;

    logic [31:0]   b_m_dat, b_s_adr, b_s_dat, b_fault_adr;
    logic          b_m_ack, b_m_err, b_m_rty, b_s_we, b_fault;
    logic [N-1:0]  b_s_cyc, b_s_stb;
    logic [3:0]    b_s_sel;
    logic [N-1:0]  b_zero = '0;
    logic [N*32-1:0] b_s_dat_in = {32'hB300_0000, 32'hB200_0000, 32'hB100_0000, 32'hB000_0000};

    wb_shared_bus #(
        .N_SLAVES       (N),
        .SLAVE_BASE     ({32'h4000_0000, 32'h3000_0000, 32'h2000_0000, 32'h1000_0000}),
        .SLAVE_MASK     ({4{32'hF000_0000}}),
        .TIMEOUT_CYCLES (T)
    ) dut_a (
        .clk_i (clk), .rst_i (rst),
        .m_cyc_i (m_cyc), .m_stb_i (m_stb), .m_we_i (m_we), .m_adr_i (m_adr),
        .m_sel_i (m_sel), .m_dat_i (m_dat_w), .m_dat_o (a_m_dat),
        .m_ack_o (a_m_ack), .m_err_o (a_m_err), .m_rty_o (a_m_rty),
        .s_cyc_o (a_s_cyc), .s_stb_o (a_s_stb), .s_we_o (a_s_we), .s_adr_o (a_s_adr),
        .s_sel_o (a_s_sel), .s_dat_o (a_s_dat), .s_dat_i (sa_dat),
        .s_ack_i (sa_ack), .s_err_i (sa_err), .s_rty_i (sa_rty),
        .fault_o (a_fault), .fault_adr_o (a_fault_adr)
    );

    // Overlapping windows: slave1 sits inside slave0; its slaves ack whenever strobed.
    wb_shared_bus #(
        .N_SLAVES       (N),
        .SLAVE_BASE     ({32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h1000_0000}),
        .SLAVE_MASK     ({32'hF000_0000, 32'hF000_0000, 32'hFFFF_0000, 32'hF000_0000}),
        .TIMEOUT_CYCLES (T)
    ) dut_b (
        .clk_i (clk), .rst_i (rst),
        .m_cyc_i (m_cyc), .m_stb_i (m_stb), .m_we_i (m_we), .m_adr_i (m_adr),
        .m_sel_i (m_sel), .m_dat_i (m_dat_w), .m_dat_o (b_m_dat),
        .m_ack_o (b_m_ack), .m_err_o (b_m_err), .m_rty_o (b_m_rty),
        .s_cyc_o (b_s_cyc), .s_stb_o (b_s_stb), .s_we_o (b_s_we), .s_adr_o (b_s_adr),
        .s_sel_o (b_s_sel), .s_dat_o (b_s_dat), .s_dat_i (b_s_dat_in),
        .s_ack_i (b_s_stb), .s_err_i (b_zero), .s_rty_i (b_zero),
        .fault_o (b_fault), .fault_adr_o (b_fault_adr)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest_hit(input logic [31:0] adr);
        for (int k = 0; k < N; k++) begin
            if ((adr & MASK_A) == (BASE_A[k] & MASK_A)) return k;
        end
        return -1;
    endfunction

    // Reference model of dut_a: phase 0 = no transfer, 1 = slave owns the transfer
    // (waited = cycles spent without a termination), 2 = interconnect error cycle.
    int          phase  = 0;
    int          owner  = 0;
    int          waited = 0;
    logic [31:0] fadr   = '0;
    logic        chk_en = 1'b0;
    logic        resp_seen = 1'b0;
    int          scnt [N] = '{0, 0, 0, 0};

    logic [N-1:0] e_cyc, e_stb;
    logic         e_ack, e_err, e_rty, e_fault, live;
    logic [31:0]  e_dat;
    int           hit;

    always @(negedge clk) begin
        e_cyc = '0; e_stb = '0; e_ack = 1'b0; e_err = 1'b0; e_rty = 1'b0; e_fault = 1'b0;
        e_dat = '0;
        live  = (phase == 1) && (waited < T);
        if (live) begin
            e_cyc[owner] = m_cyc;
            e_stb[owner] = m_cyc & m_stb;
        end
        if (phase == 1) e_dat = sa_dat[owner*32 +: 32];
        if (!rst) begin
            if (live && m_cyc) begin
                if (sa_err[owner])      e_err = 1'b1;
                else if (sa_rty[owner]) e_rty = 1'b1;
                else if (sa_ack[owner]) e_ack = 1'b1;
            end
            if (phase == 2) begin
                e_err   = 1'b1;
                e_fault = 1'b1;
            end
        end
        if (chk_en) begin
            check("slave cyc/stb", {a_s_cyc, a_s_stb}, {e_cyc, e_stb});
            check("master resp ack/err/rty", {a_m_ack, a_m_err, a_m_rty}, {e_ack, e_err, e_rty});
            check("read data", a_m_dat, e_dat);
            check("fault/fault_adr", {a_fault, a_fault_adr}, {e_fault, fadr});
            check("broadcast", {a_s_we, a_s_adr, a_s_sel, a_s_dat}, {m_we, m_adr, m_sel, m_dat_w});
        end
        resp_seen = e_ack | e_err | e_rty;
        for (int k = 0; k < N; k++) scnt[k] = e_stb[k] ? scnt[k] + 1 : 0;

        if (rst) begin
            phase = 0; waited = 0; fadr = '0;
        end else if (phase == 0) begin
            if (m_cyc && m_stb) begin
                hit = lowest_hit(m_adr);
                if (hit < 0) phase = 2;
                else begin phase = 1; owner = hit; waited = 0; end
            end
        end else if (phase == 1) begin
            if (!m_cyc)                     phase = 0;
            else if (waited == T)           phase = 2;
            else if (e_ack | e_err | e_rty) phase = 0;
            else                            waited++;
        end else begin
            fadr  = m_adr;
            phase = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek();
        @(negedge clk);
        #1;
    endtask

    task automatic start(input logic [31:0] adr, input logic we);
        m_cyc = 1'b1; m_stb = 1'b1; m_adr = adr; m_we = we;
        m_sel = 4'($urandom); m_dat_w = $urandom;
    endtask

    task automatic idle_master();
        m_cyc = 1'b0; m_stb = 1'b0;
    endtask

    int   lat  [N];
    int   kind [N];
    logic busy;

    task automatic new_transfer();
        int r;
        logic [31:0] adr;
        r   = $urandom_range(0, 5);
        adr = $urandom;
        if (r < 4)       adr[31:28] = 4'(r + 1);
        else if (r == 4) adr[31:28] = 4'($urandom_range(5, 15));
        else             adr[31:28] = 4'h0;
        start(adr, 1'($urandom));
        for (int k = 0; k < N; k++) begin
            lat[k]  = ($urandom_range(0, 5) == 0) ? NEVER : $urandom_range(0, 3);
            kind[k] = $urandom_range(0, 5);
        end
        busy = 1'b1;
    endtask

    initial begin
        tick();
        chk_en = 1'b1;
        peek();
        check("reset state", {a_s_cyc, a_s_stb, a_m_ack, a_m_err, a_m_rty, a_m_dat, a_fault, a_fault_adr}, '0);
        tick(); rst = 1'b0;

        // Read with slave1 acking two cycles into its strobe.
        tick(); start(32'h2000_0010, 1'b0);
        peek(); check("s1 decode cycle no stb", a_s_stb, 4'b0000);
        tick(); peek(); check("s1 stb to slave1 only", a_s_stb, 4'b0010);
        tick(); peek(); check("s1 no ack yet", a_m_ack, 1'b0);
        tick(); sa_ack[1] = 1'b1; sa_dat[63:32] = 32'hDEAD_BEEF;
        peek(); check("s1 ack with data", {a_m_ack, a_m_dat}, {1'b1, 32'hDEAD_BEEF});
        tick(); sa_ack = '0; idle_master();
        peek(); check("s1 ack single cycle", a_m_ack, 1'b0);

        // Unmapped write.
        tick(); start(32'h5000_0000, 1'b1);
        peek(); check("s2 no err in decode cycle", {a_m_err, a_s_stb}, 5'b0);
        tick(); peek(); check("s2 decode error", {a_m_err, a_fault, a_s_stb}, {1'b1, 1'b1, 4'b0000});
        tick(); idle_master();
        peek(); check("s2 fault adr latched", {a_m_err, a_fault, a_fault_adr}, {1'b0, 1'b0, 32'h5000_0000});

        // Slave2 never answers: watchdog.
        tick(); start(32'h3000_0000, 1'b0);
        for (int i = 1; i <= T; i++) begin
            tick(); peek(); check("s3 stb held while waiting", {a_s_stb, a_m_err}, {4'b0100, 1'b0});
        end
        tick(); peek(); check("s3 stb dropped at timeout", {a_s_stb, a_m_err}, {4'b0000, 1'b0});
        tick(); peek(); check("s3 timeout error", {a_m_err, a_fault}, 2'b11);
        tick(); idle_master();
        peek(); check("s3 fault adr latched", a_fault_adr, 32'h3000_0000);

        // Simultaneous ack+err, then a foreign ack and rty-over-ack.
        tick(); start(32'h1000_0000, 1'b0);
        tick(); sa_ack[0] = 1'b1; sa_err[0] = 1'b1;
        peek(); check("s4 err beats ack", {a_m_ack, a_m_err, a_m_rty, a_fault}, 4'b0100);
        tick(); sa_ack = '0; sa_err = '0; idle_master();
        tick(); start(32'h1000_0000, 1'b0);
        tick(); sa_ack[3] = 1'b1;
        peek(); check("s4 foreign ack ignored", {a_m_ack, a_m_err, a_m_rty}, 3'b000);
        tick(); sa_ack[3] = 1'b0; sa_ack[0] = 1'b1; sa_rty[0] = 1'b1;
        peek(); check("s4 rty beats ack", {a_m_ack, a_m_err, a_m_rty}, 3'b001);
        tick(); sa_ack = '0; sa_rty = '0; idle_master();

        // Abort, then reset mid-transfer.
        tick(); start(32'h2000_0000, 1'b0);
        tick(); peek(); check("s5 active stb", a_s_stb, 4'b0010);
        tick(); idle_master(); sa_ack[1] = 1'b1;
        peek(); check("s5 abort drops stb, no resp", {a_s_cyc, a_s_stb, a_m_ack, a_m_err, a_m_rty}, '0);
        tick(); sa_ack = '0;
        tick(); start(32'h4000_0000, 1'b0);
        tick(); peek(); check("s5 active stb slave3", a_s_stb, 4'b1000);
        tick(); rst = 1'b1;
        peek(); check("s5 no resp during reset", {a_m_ack, a_m_err, a_m_rty}, 3'b000);
        tick(); rst = 1'b0; idle_master();
        peek(); check("s5 reset values", {a_s_cyc, a_s_stb, a_m_ack, a_m_err, a_m_rty, a_m_dat, a_fault, a_fault_adr}, '0);

        // Overlapping windows on dut_b, with a back-to-back held strobe.
        tick(); start(32'h1000_0004, 1'b0);
        tick(); peek(); check("s6 lowest index wins", {b_s_stb, b_m_ack, b_m_dat}, {4'b0001, 1'b1, 32'hB000_0000});
        tick(); m_adr = 32'h1000_0008;
        peek(); check("s6 re-decode cycle", {b_s_stb, b_m_ack}, 5'b0);
        tick(); peek(); check("s6 second read acked", {b_s_stb, b_m_ack, b_m_dat}, {4'b0001, 1'b1, 32'hB000_0000});
        tick(); idle_master();

        // Randomized traffic against the reference model.
        busy = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            tick();
            rst = 1'b0;
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1; busy = 1'b0; idle_master();
            end else if (busy && resp_seen) begin
                if ($urandom_range(0, 2) == 0) new_transfer();
                else begin idle_master(); busy = 1'b0; end
            end else if (busy) begin
                if ($urandom_range(0, 59) == 0) begin idle_master(); busy = 1'b0; end
            end else if ($urandom_range(0, 1) == 0) begin
                new_transfer();
            end
            for (int k = 0; k < N; k++) begin
                sa_ack[k] = 1'b0; sa_err[k] = 1'b0; sa_rty[k] = 1'b0;
                if (lat[k] != NEVER && scnt[k] > lat[k]) begin
                    case (kind[k])
                        4:       sa_err[k] = 1'b1;
                        5:       sa_rty[k] = 1'b1;
                        default: sa_ack[k] = 1'b1;
                    endcase
                end
                if ($urandom_range(0, 15) == 0) {sa_ack[k], sa_err[k], sa_rty[k]} = 3'($urandom);
                sa_dat[k*32 +: 32] = $urandom;
            end
        end
        tick(); rst = 1'b0; idle_master(); sa_ack = '0; sa_err = '0; sa_rty = '0;
        tick(); tick();
        peek();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
